pdp8_front_panel_top: RTL and testbench
=======================================

Name: pdp8_front_panel_top

Overview:
- Self-contained PDP-8 subset system for an FPGA board: 12-bit CPU, 4096x12 memory with per-word valid bits, and a front panel (buttons, switches, LEDs, 4-digit octal seven-segment display).
- Operator deposits a program through the switches, loads the PC, then raises the run switch.
- Debug outputs expose the memory bus handshake for trace benches.

Parameters:
- CLK_HZ, 50_000_000, clock frequency; sets the display refresh divider.
- REFRESH_HZ, 1000, per-digit display refresh rate.

Ports:
- clk  in  1  system clock
- btnCpuReset  in  1  reset, asynchronous, active-low
- btnc  in  1  display select (toggles PC/AC)
- btnu  in  1  single step
- btnd  in  1  deposit
- btnl  in  1  load PC
- btnr  in  1  load AC
- sw  in  13  sw[12]=run, sw[11:0]=data/switch register
- led  out  16  [11:0] displayed value, [12] running, [13] instruction-done pulse, [14] link, [15] halted
- an  out  8  digit enables, active-low; an[7:4] always 1
- seg  out  7  segments, active-low
- dp  out  1  always 1 (off)
- address  out  12  memory address
- read_data, write_data  out  12  memory bus data
- read_enable, write_enable  out  1  memory request strobes
- read_type  out  1  0=instruction fetch, 1=data read
- mem_finished  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - PC, AC, L, MQ, IR, MB and EA = 0; every valid bit = 0; halted = 0.
  - Display shows PC; every strobe and led output = 0.
- Buttons: 2-flop synchronized; act on the rising edge only.
  - Load PC: PC=sw[11:0].
  - Load AC: AC=sw[11:0].
  - Deposit: mem[PC]=sw[11:0], valid[PC]=1, PC=PC+1 (wraps 7777->0000).
  - Panel buttons are ignored while the CPU is running.
- Memory: synchronous. mem_finished pulses in the cycle after a strobe, together with read_data; a write and its valid-bit set happen on that edge. A read of an invalid word returns 0000.
- Run control:
  - CPU runs while sw[12]=1 and halted=0; led[12]=running.
  - HLT sets halted and drops led[12].
  - Clearing sw[12] clears halted and stops at the next instruction boundary.
  - With sw[12]=0, btnu executes exactly one instruction.
- FSM: IDLE -> FETCH (IF read at PC, PC++) -> DECODE.
  - Memory-reference addressing: EA = {IR[7] ? PC_of_instr[11:7] : 0, IR[6:0]}.
  - Indirect (IR[8]): one extra data read. If the pointer EA is in 0010-0017, the pointer is pre-incremented and written back before use.
  - Per-opcode execute states, then DONE (led[13] high one cycle) -> IDLE.
- Opcodes:
  - 0 AND: AC &= M.
  - 1 TAD: {L,AC} += M; carry complements L.
  - 2 ISZ: M+1 written back; PC++ if result 0000.
  - 3 DCA: M=AC, AC=0.
  - 4 JMS: M=PC, PC=EA+1.
  - 5 JMP: PC=EA.
  - 6 IOT: no-op.
- Group1 (7, IR[8]=0), applied in order:
  - CLA(7) and CLL(6).
  - CMA(5) and CML(4).
  - IAC(0), 13-bit carry into L.
  - Rotate through L: RAR(3), RAL(2); IR[1] makes it a two-bit rotate (RTR/RTL). RAR and RAL together do nothing.
- Group2 (IR[8]=1, IR[0]=0):
  - Skip conditions: SMA(6) = AC[11], SZA(5) = AC==0, SNL(4) = L.
  - IR[3]=0: skip if the OR of the selected conditions is true.
  - IR[3]=1: skip if every selected condition is false. With no condition selected (SKP) it always skips.
  - Then CLA(7), OSR(2) AC|=sw[11:0], HLT(1).
- Group3 (IR[8]=1, IR[0]=1):
  - CLA(7) first.
  - MQA(6)+MQL(4) together = swap.
  - Otherwise MQA: AC|=MQ; MQL: MQ=AC, AC=0.
- All arithmetic is modulo 4096; PC wraps.
- Display:
  - Four octal digits of PC or AC, multiplexed at REFRESH_HZ, digit 0 = least significant octal digit.
  - led[11:0] mirrors the displayed value.
- Reset asserted mid-instruction: immediate return to the reset state; memory contents are kept, valid bits are cleared.

Optional Feature:
- DEBOUNCE_EN defined: each button must stay stable for 10 ms (counted in CLK_HZ cycles) before its edge is accepted.
- DEBOUNCE_EN undefined: synchronizer and edge detect only; a 1-cycle change is accepted (simulation speed).

Test Plan:
- Reset, then Load PC 0200, deposit 7200, 1205, 3206, 7402, 0000, 0017 -> valid 0200-0205. Run -> AC=0000, mem[0206]=0017, halted, led[12] falls.
- TAD 7777 + 0001 with L=0 -> AC=0000, L=1. ISZ on 7777 -> stored 0000 and the next instruction is skipped.
- Indirect through 0010 holding 0377 -> pointer written back as 0400, operand read from 0400, read_type=1 on both reads.
- JMS 0300 at PC 0200 -> mem[0300]=0201, PC=0301. JMP I back -> PC=0201.
- Group2: AC=4000 SMA skips, SPA does not. SKP always skips. OSR with sw=0055 ORs into AC.
- Group3: AC=1234, MQL -> MQ=1234, AC=0. MQA -> AC=1234. SWP exchanges AC and MQ.

Source files
------------

// File: rtl/pdp8_front_panel_top.sv
// pdp8_front_panel_top: PDP-8 subset CPU with a 4096x12 memory (per-word
// valid bits) and a board front panel.
//   clk, btnCpuReset (async, active-low)
//   btnc display select, btnu single step, btnd deposit, btnl load PC,
//   btnr load AC; sw[12] run, sw[11:0] switch register
//   led[11:0] displayed value, [12] running, [13] instruction done,
//   [14] link, [15] halted; an/seg/dp active-low octal display
//   address/read_data/write_data/read_enable/write_enable/read_type/
//   mem_finished expose the memory bus.
// Optional macro DEBOUNCE_EN: buttons must be stable 10 ms before use.
module pdp8_front_panel_top #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned REFRESH_HZ = 1000
) (
    input  logic        clk,
    input  logic        btnCpuReset,
    input  logic        btnc,
    input  logic        btnu,
    input  logic        btnd,
    input  logic        btnl,
    input  logic        btnr,
    input  logic [12:0] sw,
    output logic [15:0] led,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [11:0] address,
    output logic [11:0] read_data,
    output logic [11:0] write_data,
    output logic        read_enable,
    output logic        write_enable,
    output logic        read_type,
    output logic        mem_finished
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_IND_RD, S_IND_WAIT, S_IND_WR,
        S_EXEC, S_MEM_EXEC, S_ISZ_WR, S_DONE
    } state_t;

    state_t      state, next_state;
    logic [11:0] pc, ac, mq, ir, mb, ea, ipc;
    logic        l, halted, show_ac;
    logic [11:0] mem [4096];
    logic [4095:0] valid;

    // Button conditioning: {btnr, btnl, btnd, btnu, btnc}
    logic [4:0] btn_s1, btn_s2, btn_stable, btn_prev, btn_rise;

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_prev <= '0;
        end else begin
            btn_s1   <= {btnr, btnl, btnd, btnu, btnc};
            btn_s2   <= btn_s1;
            btn_prev <= btn_stable;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned DB_CYCLES = CLK_HZ / 100;
    localparam int unsigned DB_W      = $clog2(DB_CYCLES + 1);
    logic [DB_W-1:0] db_cnt [5];

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            btn_stable <= '0;
            for (int unsigned i = 0; i < 5; i++) db_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 5; i++) begin
                if (btn_s2[i] == btn_stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    btn_stable[i] <= btn_s2[i];
                    db_cnt[i]     <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign btn_stable = btn_s2;
`endif

    assign btn_rise = btn_stable & ~btn_prev;

    logic running, step_go, panel_ok, autoinc;
    assign running  = sw[12] && !halted;
    assign step_go  = btn_rise[1] && !sw[12];
    assign panel_ok = (state == S_IDLE) && !running && !step_go;
    assign autoinc  = (ea[11:3] == 9'd1);

    // Operate-group results, all evaluated on the pre-instruction AC/L.
    logic [12:0] g1, tad_sum;
    logic [11:0] cla_ac;
    logic        g2_cond, g2_skip;

    always_comb begin
        g1 = {l, ac};
        if (ir[7]) g1[11:0] = '0;
        if (ir[6]) g1[12] = 1'b0;
        if (ir[5]) g1[11:0] = ~g1[11:0];
        if (ir[4]) g1[12] = ~g1[12];
        if (ir[0]) g1 = g1 + 13'd1;
        if (ir[3] && !ir[2])
            g1 = ir[1] ? {g1[1:0], g1[12:2]} : {g1[0], g1[12:1]};
        else if (ir[2] && !ir[3])
            g1 = ir[1] ? {g1[10:0], g1[12:11]} : {g1[11:0], g1[12]};
    end

    assign cla_ac  = ir[7] ? '0 : ac;
    assign g2_cond = (ir[6] & ac[11]) | (ir[5] & (ac == '0)) | (ir[4] & l);
    assign g2_skip = ir[3] ? ~g2_cond : g2_cond;
    assign tad_sum = {1'b0, ac} + {1'b0, read_data};

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) state <= S_IDLE;
        else              state <= next_state;
    end

    // Every memory strobe is answered on the following cycle, so states that
    // consume read_data simply follow the state that issued the strobe.
    always_comb begin
        next_state   = state;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        read_type    = 1'b0;
        address      = pc;
        write_data   = '0;
        case (state)
            S_IDLE: begin
                if (running || step_go) begin
                    next_state = S_FETCH;
                end else if (panel_ok && btn_rise[2]) begin
                    write_enable = 1'b1;
                    write_data   = sw[11:0];
                end
            end
            S_FETCH: begin
                read_enable = 1'b1;
                next_state  = S_DECODE;
            end
            S_DECODE:
                next_state = (read_data[11:9] < 3'd6 && read_data[8]) ? S_IND_RD : S_EXEC;
            S_IND_RD: begin
                read_enable = 1'b1;
                read_type   = 1'b1;
                address     = ea;
                next_state  = S_IND_WAIT;
            end
            S_IND_WAIT: next_state = autoinc ? S_IND_WR : S_EXEC;
            S_IND_WR: begin
                write_enable = 1'b1;
                address      = ea;
                write_data   = mb;
                next_state   = S_EXEC;
            end
            S_EXEC: begin
                next_state = S_DONE;
                case (ir[11:9])
                    3'd0, 3'd1, 3'd2: begin
                        read_enable = 1'b1;
                        read_type   = 1'b1;
                        address     = ea;
                        next_state  = S_MEM_EXEC;
                    end
                    3'd3: begin
                        write_enable = 1'b1;
                        address      = ea;
                        write_data   = ac;
                    end
                    3'd4: begin
                        write_enable = 1'b1;
                        address      = ea;
                        write_data   = pc;
                    end
                    default: ;
                endcase
            end
            S_MEM_EXEC: next_state = (ir[11:9] == 3'd2) ? S_ISZ_WR : S_DONE;
            S_ISZ_WR: begin
                write_enable = 1'b1;
                address      = ea;
                write_data   = mb;
                next_state   = S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            pc <= '0; ac <= '0; mq <= '0; ir <= '0; mb <= '0; ea <= '0; ipc <= '0;
            l <= 1'b0; halted <= 1'b0; show_ac <= 1'b0;
        end else begin
            if (btn_rise[0]) show_ac <= ~show_ac;
            if (!sw[12]) halted <= 1'b0;
            case (state)
                S_IDLE: if (panel_ok) begin
                    if (btn_rise[2])      pc <= pc + 12'd1;
                    else if (btn_rise[3]) pc <= sw[11:0];
                    if (btn_rise[4])      ac <= sw[11:0];
                end
                S_FETCH: begin
                    ipc <= pc;
                    pc  <= pc + 12'd1;
                end
                S_DECODE: begin
                    ir <= read_data;
                    ea <= {read_data[7] ? ipc[11:7] : 5'd0, read_data[6:0]};
                end
                S_IND_WAIT: begin
                    if (autoinc) mb <= read_data + 12'd1;
                    else         ea <= read_data;
                end
                S_IND_WR: ea <= mb;
                S_EXEC: case (ir[11:9])
                    3'd3: ac <= '0;
                    3'd4: pc <= ea + 12'd1;
                    3'd5: pc <= ea;
                    3'd7: begin
                        if (!ir[8]) begin
                            {l, ac} <= g1;
                        end else if (!ir[0]) begin
                            if (g2_skip) pc <= pc + 12'd1;
                            ac <= cla_ac | (ir[2] ? sw[11:0] : 12'd0);
                            if (ir[1]) halted <= 1'b1;
                        end else if (ir[6] && ir[4]) begin
                            ac <= mq;
                            mq <= cla_ac;
                        end else if (ir[6]) begin
                            ac <= cla_ac | mq;
                        end else if (ir[4]) begin
                            mq <= cla_ac;
                            ac <= '0;
                        end else begin
                            ac <= cla_ac;
                        end
                    end
                    default: ;
                endcase
                S_MEM_EXEC: case (ir[11:9])
                    3'd0:    ac <= ac & read_data;
                    3'd1:    begin ac <= tad_sum[11:0]; l <= l ^ tad_sum[12]; end
                    default: mb <= read_data + 12'd1;
                endcase
                S_ISZ_WR: if (mb == '0) pc <= pc + 12'd1;
                default: ;
            endcase
        end
    end

    // Memory contents survive reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (write_enable) mem[address] <= write_data;
    end

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            valid        <= '0;
            read_data    <= '0;
            mem_finished <= 1'b0;
        end else begin
            mem_finished <= read_enable | write_enable;
            if (write_enable) valid[address] <= 1'b1;
            if (read_enable)  read_data <= valid[address] ? mem[address] : 12'd0;
        end
    end

    // Display multiplexing
    localparam int unsigned DIV = CLK_HZ / REFRESH_HZ;
    logic [31:0] div_cnt;
    logic [1:0]  digit;
    logic [11:0] shown;
    logic [2:0]  oct;

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            div_cnt <= '0;
            digit   <= '0;
        end else if (div_cnt == DIV - 1) begin
            div_cnt <= '0;
            digit   <= digit + 2'd1;
        end else begin
            div_cnt <= div_cnt + 32'd1;
        end
    end

    assign shown = show_ac ? ac : pc;

    always_comb begin
        case (digit)
            2'd0:    oct = shown[2:0];
            2'd1:    oct = shown[5:3];
            2'd2:    oct = shown[8:6];
            default: oct = shown[11:9];
        endcase
        case (oct)  // {g,f,e,d,c,b,a}, active-low
            3'd0:    seg = 7'h40;
            3'd1:    seg = 7'h79;
            3'd2:    seg = 7'h24;
            3'd3:    seg = 7'h30;
            3'd4:    seg = 7'h19;
            3'd5:    seg = 7'h12;
            3'd6:    seg = 7'h02;
            default: seg = 7'h78;
        endcase
    end

    assign an  = {4'hF, ~(4'b0001 << digit)};
    assign dp  = 1'b1;
    assign led = {halted, l, (state == S_DONE), running, shown};
endmodule

// File: tb/tb_pdp8_front_panel_top.sv
module tb_pdp8_front_panel_top;
    logic        clk = 1'b0;
    logic        btnCpuReset = 1'b0;
    logic        btnc = 1'b0, btnu = 1'b0, btnd = 1'b0, btnl = 1'b0, btnr = 1'b0;
    logic [12:0] sw = '0;
    logic [15:0] led;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [11:0] address, read_data, write_data;
    logic        read_enable, write_enable, read_type, mem_finished;

    int vectors = 0;
    int miscompares = 0;
    logic disp_is_ac = 1'b0;
    logic rt10 = 1'b0, rt10_seen = 1'b0, rt400 = 1'b0, rt400_seen = 1'b0;

    localparam int B_DISP = 0, B_STEP = 1, B_DEP = 2, B_LPC = 3, B_LAC = 4;

    pdp8_front_panel_top #(.CLK_HZ(50_000_000), .REFRESH_HZ(1000)) dut (
        .clk(clk), .btnCpuReset(btnCpuReset),
        .btnc(btnc), .btnu(btnu), .btnd(btnd), .btnl(btnl), .btnr(btnr),
        .sw(sw), .led(led), .an(an), .seg(seg), .dp(dp),
        .address(address), .read_data(read_data), .write_data(write_data),
        .read_enable(read_enable), .write_enable(write_enable),
        .read_type(read_type), .mem_finished(mem_finished)
    );

    always #5 clk = ~clk;

    // Record the read type of the pointer and operand reads of the indirect test.
    always @(negedge clk) begin
        if (read_enable && address == 12'o0010) begin rt10 <= read_type; rt10_seen <= 1'b1; end
        if (read_enable && address == 12'o0400) begin rt400 <= read_type; rt400_seen <= 1'b1; end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %o expected %o", tag, obs, exp);
        end
    endtask

    task automatic check12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        check(tag, {4'd0, obs}, {4'd0, exp});
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        check(tag, {15'd0, obs}, {15'd0, exp});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b);
        @(negedge clk);
        case (b)
            B_DISP:  btnc = 1'b1;
            B_STEP:  btnu = 1'b1;
            B_DEP:   btnd = 1'b1;
            B_LPC:   btnl = 1'b1;
            default: btnr = 1'b1;
        endcase
        tick(3);
        btnc = 1'b0; btnu = 1'b0; btnd = 1'b0; btnl = 1'b0; btnr = 1'b0;
        tick(3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sw = '0;
        btnCpuReset = 1'b0;
        tick(3);
        btnCpuReset = 1'b1;
        tick(2);
        disp_is_ac = 1'b0;
    endtask

    task automatic load_pc(input logic [11:0] v);
        sw[11:0] = v;
        press(B_LPC);
    endtask

    task automatic load_ac(input logic [11:0] v);
        sw[11:0] = v;
        press(B_LAC);
    endtask

    task automatic dep(input logic [11:0] v);
        sw[11:0] = v;
        press(B_DEP);
    endtask

    task automatic show(input logic want_ac);
        if (disp_is_ac != want_ac) begin
            press(B_DISP);
            disp_is_ac = want_ac;
        end
    endtask

    task automatic run_to_halt(input string tag);
        int n;
        n = 0;
        sw[12] = 1'b1;
        while (led[15] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check1(tag, led[15], 1'b1);
        tick(2);
    endtask

    task automatic stop_run();
        sw[12] = 1'b0;
        tick(2);
    endtask

    initial begin
        // Reset state and basic program: CLA; TAD 205; DCA 206; HLT
        do_reset();
        check("reset_led", led, 16'h0000);
        check1("reset_rd_en", read_enable, 1'b0);
        check1("reset_wr_en", write_enable, 1'b0);
        check("reset_an", {8'd0, an}, 16'h00FE);
        check("reset_seg", {9'd0, seg}, 16'h0040);
        check1("reset_dp", dp, 1'b1);
        load_pc(12'o0200);
        dep(12'o7200); dep(12'o1205); dep(12'o3206);
        dep(12'o7402); dep(12'o0000); dep(12'o0017);
        check12("dep_pc", led[11:0], 12'o0206);
        check1("dep_valid_200", dut.valid[12'o0200], 1'b1);
        check1("dep_valid_205", dut.valid[12'o0205], 1'b1);
        check1("invalid_206", dut.valid[12'o0206], 1'b0);
        load_pc(12'o0200);
        sw[12] = 1'b1;
        @(negedge clk);
        check1("running_led", led[12], 1'b1);
        run_to_halt("t1_halt");
        check1("t1_running_off", led[12], 1'b0);
        check12("t1_pc", led[11:0], 12'o0204);
        check("t1_seg_digit0", {9'd0, seg}, 16'h0019);
        check12("t1_mem206", dut.mem[12'o0206], 12'o0017);
        check1("t1_valid206", dut.valid[12'o0206], 1'b1);
        show(1'b1);
        check12("t1_ac", led[11:0], 12'o0000);
        stop_run();
        check1("t1_halt_cleared", led[15], 1'b0);

        // TAD overflow into link, ISZ skip
        do_reset();
        load_pc(12'o0200);
        dep(12'o7300); dep(12'o1210); dep(12'o1211); dep(12'o2212);
        dep(12'o7402); dep(12'o7402); dep(12'o0000); dep(12'o0000);
        dep(12'o7777); dep(12'o0001); dep(12'o7777);
        load_pc(12'o0200);
        run_to_halt("t2_halt");
        check12("t2_pc_after_skip", led[11:0], 12'o0206);
        check1("t2_link", led[14], 1'b1);
        check12("t2_isz_mem", dut.mem[12'o0212], 12'o0000);
        show(1'b1);
        check12("t2_ac", led[11:0], 12'o0000);
        stop_run();

        // Single step, auto-index indirect, JMS and JMP I
        do_reset();
        load_pc(12'o0010); dep(12'o0377);
        load_pc(12'o0400); dep(12'o0123);
        load_pc(12'o0300); dep(12'o0000); dep(12'o5700);
        load_pc(12'o0200);
        dep(12'o7300); dep(12'o1410); dep(12'o4300); dep(12'o7402);
        load_pc(12'o0200);
        press(B_STEP);
        tick(20);
        check12("step_pc", led[11:0], 12'o0201);
        check1("step_not_halted", led[15], 1'b0);
        run_to_halt("t3_halt");
        check12("t3_pc", led[11:0], 12'o0204);
        check12("t3_autoinc_ptr", dut.mem[12'o0010], 12'o0400);
        check12("t3_jms_ret", dut.mem[12'o0300], 12'o0203);
        check1("t3_ptr_rtype_seen", rt10_seen, 1'b1);
        check1("t3_ptr_rtype", rt10, 1'b1);
        check1("t3_opnd_rtype_seen", rt400_seen, 1'b1);
        check1("t3_opnd_rtype", rt400, 1'b1);
        show(1'b1);
        check12("t3_ac", led[11:0], 12'o0123);
        stop_run();

        // Group 2 skips and OSR
        do_reset();
        load_pc(12'o0200);
        dep(12'o7500); dep(12'o7402); dep(12'o7510); dep(12'o7001);
        dep(12'o7410); dep(12'o7402); dep(12'o7404); dep(12'o7402);
        load_ac(12'o4000);
        load_pc(12'o0200);
        sw[11:0] = 12'o0055;
        run_to_halt("t4_halt");
        check12("t4_pc", led[11:0], 12'o0210);
        show(1'b1);
        check12("t4_ac", led[11:0], 12'o4055);
        stop_run();

        // Group 3: MQL, MQA, SWP
        do_reset();
        load_pc(12'o0200);
        dep(12'o7421); dep(12'o7402); dep(12'o7501); dep(12'o7402);
        dep(12'o7001); dep(12'o7521); dep(12'o7402); dep(12'o7501); dep(12'o7402);
        load_ac(12'o1234);
        load_pc(12'o0200);
        show(1'b1);
        run_to_halt("t5_mql_halt");
        check12("t5_mql_ac", led[11:0], 12'o0000);
        stop_run();
        run_to_halt("t5_mqa_halt");
        check12("t5_mqa_ac", led[11:0], 12'o1234);
        stop_run();
        run_to_halt("t5_swp_halt");
        check12("t5_swp_ac", led[11:0], 12'o1234);
        stop_run();
        run_to_halt("t5_mq_halt");
        check12("t5_mq_or_ac", led[11:0], 12'o1235);
        show(1'b0);
        check12("t5_pc", led[11:0], 12'o0211);
        stop_run();

        // Reset mid-instruction: state and valid bits cleared, memory kept
        load_pc(12'o0200);
        sw[12] = 1'b1;
        tick(3);
        do_reset();
        check("midreset_led", led, 16'h0000);
        check1("midreset_valid", dut.valid[12'o0200], 1'b0);
        check12("midreset_mem_kept", dut.mem[12'o0200], 12'o7421);
        check1("midreset_rd_en", read_enable, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
